// File: rtl/cbc_pkg.sv
// Shared types and constants for the CBC command/response link (state enum, byte counts, frame size).
package cbc_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_TX, ST_WAIT_RSP, ST_DONE} cbc_state_t;

    localparam int BAUD_DIV_DEF = 868;
    localparam int CMD_BYTES    = 3;
    localparam int RSP_BYTES    = 2;
    localparam int FRAME_BITS   = 10;
endpackage

// File: rtl/cbc_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop sync, start detect, mid-bit sampling, stop check, glitch rejection.
// With CBC_CMD_TIMEOUT_EN defined, a start-edge strobe is also exported.
module cbc_uart_rx_byte
    import cbc_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       arm,
`ifdef CBC_CMD_TIMEOUT_EN
    output logic       start,
`endif
    output logic [7:0] data,
    output logic       byte_vld,
    output logic       frm_err
);
    localparam int CW = $clog2(BAUD_DIV);

    logic          s1_reg, s2_reg, prev_reg;
    logic          active_reg, active_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    idx_reg, idx_next;
    logic [7:0]    data_reg, data_next;
    logic          vld_reg, vld_next;
    logic          ferr_reg, ferr_next;
    logic          fall;

    assign fall = prev_reg & ~s2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg     <= 1'b1;
            s2_reg     <= 1'b1;
            prev_reg   <= 1'b1;
            active_reg <= 1'b0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            data_reg   <= '0;
            vld_reg    <= 1'b0;
            ferr_reg   <= 1'b0;
        end else begin
            s1_reg     <= rx;
            s2_reg     <= s1_reg;
            prev_reg   <= s2_reg;
            active_reg <= active_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            data_reg   <= data_next;
            vld_reg    <= vld_next;
            ferr_reg   <= ferr_next;
        end
    end

    always_comb begin
        active_next = active_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        data_next   = data_reg;
        vld_next    = 1'b0;
        ferr_next   = 1'b0;
        if (!arm) begin
            active_next = 1'b0;
        end else if (!active_reg) begin
            if (fall) begin
                // Preload so the first sample lands half a bit after the edge.
                active_next = 1'b1;
                cnt_next    = CW'(BAUD_DIV - BAUD_DIV / 2);
                idx_next    = 4'd0;
            end
        end else if (cnt_reg == CW'(BAUD_DIV - 1)) begin
            cnt_next = '0;
            if (idx_reg == 4'd0) begin
                if (s2_reg) active_next = 1'b0;
                else        idx_next    = 4'd1;
            end else if (idx_reg == 4'(FRAME_BITS - 1)) begin
                vld_next    = 1'b1;
                ferr_next   = ~s2_reg;
                active_next = 1'b0;
            end else begin
                data_next = {s2_reg, data_reg[7:1]};
                idx_next  = idx_reg + 4'd1;
            end
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

`ifdef CBC_CMD_TIMEOUT_EN
    assign start = arm & ~active_reg & fall;
`endif
    assign data     = data_reg;
    assign byte_vld = vld_reg;
    assign frm_err  = ferr_reg;
endmodule

// File: rtl/cbc_cmd_master.sv
// CBC link initiator: sends a 3-byte 8N1 command on TX, collects a 2-byte response from RX.
// Defining CBC_CMD_TIMEOUT_EN adds a response timeout that raises rsp_tmo.
module cbc_cmd_master
    import cbc_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEF,
    parameter int TMO_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    input  logic        RX,
    output logic        busy,
    output logic [15:0] rsp_data,
    output logic        rsp_rdy,
    input  logic        clr_rsp_rdy,
    output logic        rsp_err,
    output logic        rsp_tmo
);
    localparam int CW = $clog2(BAUD_DIV);

    if (BAUD_DIV < 4 || TMO_CYCLES < 1) begin : g_bad_param
        $error("cbc_cmd_master: BAUD_DIV must be >= 4 and TMO_CYCLES >= 1");
    end

    cbc_state_t    state_reg, state_next;
    logic [23:0]   sh_reg, sh_next;
    logic [CW-1:0] baud_reg, baud_next;
    logic [3:0]    bit_reg, bit_next;
    logic [1:0]    byte_reg, byte_next;
    logic          tx_reg, tx_next;
    logic [15:0]   rsp_sh_reg, rsp_sh_next;
    logic          rsp_cnt_reg, rsp_cnt_next;
    logic [15:0]   rsp_data_reg, rsp_data_next;
    logic          rsp_rdy_reg, rsp_rdy_next;
    logic          rsp_err_reg, rsp_err_next;
    logic [7:0]    rx_byte;
    logic          rx_vld, rx_ferr;
`ifdef CBC_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic          rx_start;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic          rsp_tmo_reg, rsp_tmo_next;
`endif

    cbc_uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .arm      (state_reg == ST_WAIT_RSP),
`ifdef CBC_CMD_TIMEOUT_EN
        .start    (rx_start),
`endif
        .data     (rx_byte),
        .byte_vld (rx_vld),
        .frm_err  (rx_ferr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            sh_reg       <= '0;
            baud_reg     <= '0;
            bit_reg      <= '0;
            byte_reg     <= '0;
            tx_reg       <= 1'b1;
            rsp_sh_reg   <= '0;
            rsp_cnt_reg  <= 1'b0;
            rsp_data_reg <= '0;
            rsp_rdy_reg  <= 1'b0;
            rsp_err_reg  <= 1'b0;
`ifdef CBC_CMD_TIMEOUT_EN
            tmo_reg      <= '0;
            rsp_tmo_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            sh_reg       <= sh_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            byte_reg     <= byte_next;
            tx_reg       <= tx_next;
            rsp_sh_reg   <= rsp_sh_next;
            rsp_cnt_reg  <= rsp_cnt_next;
            rsp_data_reg <= rsp_data_next;
            rsp_rdy_reg  <= rsp_rdy_next;
            rsp_err_reg  <= rsp_err_next;
`ifdef CBC_CMD_TIMEOUT_EN
            tmo_reg      <= tmo_next;
            rsp_tmo_reg  <= rsp_tmo_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        sh_next       = sh_reg;
        baud_next     = baud_reg;
        bit_next      = bit_reg;
        byte_next     = byte_reg;
        tx_next       = tx_reg;
        rsp_sh_next   = rsp_sh_reg;
        rsp_cnt_next  = rsp_cnt_reg;
        rsp_data_next = rsp_data_reg;
        rsp_rdy_next  = clr_rsp_rdy ? 1'b0 : rsp_rdy_reg;
        rsp_err_next  = rsp_err_reg;
`ifdef CBC_CMD_TIMEOUT_EN
        tmo_next      = tmo_reg;
        rsp_tmo_next  = rsp_tmo_reg;
`endif
        unique case (state_reg)
            ST_IDLE: begin
                if (snd_cmd) begin
                    sh_next      = cmd;
                    baud_next    = '0;
                    bit_next     = '0;
                    byte_next    = '0;
                    tx_next      = 1'b0;
                    rsp_cnt_next = 1'b0;
                    rsp_rdy_next = 1'b0;
                    rsp_err_next = 1'b0;
`ifdef CBC_CMD_TIMEOUT_EN
                    tmo_next     = '0;
                    rsp_tmo_next = 1'b0;
`endif
                    state_next   = ST_TX;
                end
            end
            ST_TX: begin
                if (baud_reg == CW'(BAUD_DIV - 1)) begin
                    baud_next = '0;
                    if (bit_reg == 4'(FRAME_BITS - 1)) begin
                        bit_next = '0;
                        if (byte_reg == 2'(CMD_BYTES - 1)) begin
                            tx_next    = 1'b1;
                            state_next = ST_WAIT_RSP;
                        end else begin
                            byte_next = byte_reg + 2'd1;
                            sh_next   = {sh_reg[15:0], 8'h00};
                            tx_next   = 1'b0;
                        end
                    end else begin
                        bit_next = bit_reg + 4'd1;
                        // Current byte always sits in sh_reg[23:16].
                        tx_next  = (bit_reg == 4'(FRAME_BITS - 2)) ? 1'b1
                                                                    : sh_reg[{2'b10, bit_reg[2:0]}];
                    end
                end else begin
                    baud_next = baud_reg + CW'(1);
                end
            end
            ST_WAIT_RSP: begin
`ifdef CBC_CMD_TIMEOUT_EN
                if (rx_start) begin
                    tmo_next = '0;
                end else if (tmo_reg == TW'(TMO_CYCLES - 1)) begin
                    rsp_tmo_next = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
`endif
                if (rx_vld) begin
                    rsp_sh_next = {rsp_sh_reg[7:0], rx_byte};
                    if (rx_ferr) rsp_err_next = 1'b1;
                    if (rsp_cnt_reg == 1'(RSP_BYTES - 1)) state_next   = ST_DONE;
                    else                                  rsp_cnt_next = rsp_cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                rsp_data_next = rsp_sh_reg;
                rsp_rdy_next  = 1'b1;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign TX       = tx_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign rsp_data = rsp_data_reg;
    assign rsp_rdy  = rsp_rdy_reg;
    assign rsp_err  = rsp_err_reg;
`ifdef CBC_CMD_TIMEOUT_EN
    assign rsp_tmo  = rsp_tmo_reg;
`else
    assign rsp_tmo  = 1'b0;
`endif
endmodule
